// File: rtl/alu_if.sv
// Operand/result bundle for the 8-bit ALU: master drives operands and opcode, slave returns result and flags.
interface alu_if;
  localparam int unsigned W  = 8;
  localparam int unsigned OW = 3;

  logic [W-1:0]  InputA;
  logic [W-1:0]  InputB;
  logic          SC_in;
  logic [OW-1:0] OP;
  logic [W-1:0]  Out;
  logic          Zero;
  logic          Equal;
  logic          Even;
  logic          SC_out;
  logic          Zero_q;
  logic          SC_q;
  logic          Even_q;

  modport master (
    output InputA, InputB, SC_in, OP,
    input  Out, Zero, Equal, Even, SC_out, Zero_q, SC_q, Even_q
  );

  modport slave (
    input  InputA, InputB, SC_in, OP,
    output Out, Zero, Equal, Even, SC_out, Zero_q, SC_q, Even_q
  );
endinterface

// File: rtl/alu.sv
// 8-bit unsigned ALU with combinational result/flags and an optional registered status triple.
// Define ALU_STATUS_REG_EN to build the Zero_q/SC_q/Even_q flops; otherwise they are tied low.
module alu (
  input  logic CLK,
  input  logic Reset,
  alu_if.slave bus
);
  localparam int unsigned W  = 8;
  localparam int unsigned OW = 3;

  localparam logic [OW-1:0] OP_ADD  = 3'b000;
  localparam logic [OW-1:0] OP_LSH  = 3'b001;
  localparam logic [OW-1:0] OP_RSH  = 3'b010;
  localparam logic [OW-1:0] OP_XOR  = 3'b011;
  localparam logic [OW-1:0] OP_AND  = 3'b100;
  localparam logic [OW-1:0] OP_SUB  = 3'b101;
  localparam logic [OW-1:0] OP_OR   = 3'b110;
  localparam logic [OW-1:0] OP_PASS = 3'b111;

  logic [W:0]   sum_c;
  logic [W:0]   diff_c;
  logic [W-1:0] res_c;
  logic         sc_out_c;
  logic         zero_c;
  logic         equal_c;
  logic         even_c;

  // Nine-bit add/sub: bit W is carry-out for ADD and unsigned borrow for SUB.
  assign sum_c  = {1'b0, bus.InputA} + {1'b0, bus.InputB};
  assign diff_c = {1'b0, bus.InputA} - {1'b0, bus.InputB};

  always_comb begin
    res_c    = '0;
    sc_out_c = 1'b0;
    case (bus.OP)
      OP_ADD: begin
        res_c    = sum_c[W-1:0];
        sc_out_c = sum_c[W];
      end
      OP_LSH: begin
        res_c    = {bus.InputA[W-2:0], bus.SC_in};
        sc_out_c = bus.InputA[W-1];
      end
      OP_RSH: begin
        res_c    = {1'b0, bus.InputA[W-1:1]};
        sc_out_c = bus.InputA[0];
      end
      OP_XOR:  res_c = bus.InputA ^ bus.InputB;
      OP_AND:  res_c = bus.InputA & bus.InputB;
      OP_SUB: begin
        res_c    = diff_c[W-1:0];
        sc_out_c = diff_c[W];
      end
      OP_OR:   res_c = bus.InputA | bus.InputB;
      OP_PASS: res_c = bus.InputB;
      default: begin
        res_c    = '0;
        sc_out_c = 1'b0;
      end
    endcase
  end

  assign zero_c  = (res_c == W'(0));
  assign equal_c = (bus.InputA == bus.InputB);
  assign even_c  = ~res_c[0];

  assign bus.Out    = res_c;
  assign bus.Zero   = zero_c;
  assign bus.Equal  = equal_c;
  assign bus.Even   = even_c;
  assign bus.SC_out = sc_out_c;

`ifdef ALU_STATUS_REG_EN
  logic zero_d, sc_d, even_d;
  logic zero_q, sc_q, even_q;

  assign zero_d = zero_c;
  assign sc_d   = sc_out_c;
  assign even_d = even_c;

  // Reset wins over capture on the same edge.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      zero_q <= 1'b0;
      sc_q   <= 1'b0;
      even_q <= 1'b0;
    end else begin
      zero_q <= zero_d;
      sc_q   <= sc_d;
      even_q <= even_d;
    end
  end

  assign bus.Zero_q = zero_q;
  assign bus.SC_q   = sc_q;
  assign bus.Even_q = even_q;
`else
  logic unused_clk_rst_c;

  assign unused_clk_rst_c = &{1'b0, CLK, Reset};

  assign bus.Zero_q = 1'b0;
  assign bus.SC_q   = 1'b0;
  assign bus.Even_q = 1'b0;
`endif

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu; registered-flag expectations follow ALU_STATUS_REG_EN.
module tb_alu;
  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  alu_if bus ();

  alu dut (
    .CLK   (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ALU_STATUS_REG_EN
  localparam bit REG_EN = 1'b1;
`else
  localparam bit REG_EN = 1'b0;
`endif

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic sc, input logic [2:0] op);
    bus.InputA = a;
    bus.InputB = b;
    bus.SC_in  = sc;
    bus.OP     = op;
  endtask

  task automatic test_reset();
    logic [2:0] q;
    drive(8'h3C, 8'h05, 1'b1, 3'b000);
    rst = 1'b1;
    @(posedge clk); #1;
    q = {bus.Zero_q, bus.SC_q, bus.Even_q};
    n_total++;
    if (q !== 3'b000) $display("FAIL reset_state got=%b exp=000", q);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_add();
    logic [7:0] va[5] = '{8'h01, 8'hFF, 8'h80, 8'h3C, 8'h01};
    logic [7:0] vb[5] = '{8'h01, 8'h01, 8'h80, 8'h05, 8'h01};
    logic       vs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] vo[5] = '{8'h02, 8'h00, 8'h00, 8'h41, 8'h02};
    logic [3:0] vf[5] = '{4'b0110, 4'b1011, 4'b1111, 4'b0000, 4'b0110};
    for (int i = 0; i < 5; i++) begin
      drive(va[i], vb[i], vs[i], 3'b000);
      #1;
      n_total++;
      if ({bus.Out, bus.Zero, bus.Equal, bus.Even, bus.SC_out} !== {vo[i], vf[i]})
        $display("FAIL add[%0d] got out=%h zeqevc=%b exp out=%h zeqevc=%b", i, bus.Out,
                 {bus.Zero, bus.Equal, bus.Even, bus.SC_out}, vo[i], vf[i]);
      else n_pass++;
    end
  endtask

  task automatic test_shift();
    logic [7:0] va[6] = '{8'h81, 8'h00, 8'h7F, 8'h81, 8'h01, 8'hFE};
    logic [7:0] vb[6] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFE};
    logic       vs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [2:0] vp[6] = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b010};
    logic [7:0] vo[6] = '{8'h03, 8'h00, 8'hFE, 8'h40, 8'h00, 8'h7F};
    logic [3:0] vf[6] = '{4'b0001, 4'b1110, 4'b0010, 4'b0011, 4'b1011, 4'b0100};
    for (int i = 0; i < 6; i++) begin
      drive(va[i], vb[i], vs[i], vp[i]);
      #1;
      n_total++;
      if ({bus.Out, bus.Zero, bus.Equal, bus.Even, bus.SC_out} !== {vo[i], vf[i]})
        $display("FAIL shift[%0d] got out=%h zeqevc=%b exp out=%h zeqevc=%b", i, bus.Out,
                 {bus.Zero, bus.Equal, bus.Even, bus.SC_out}, vo[i], vf[i]);
      else n_pass++;
    end
  endtask

  task automatic test_sub();
    logic [7:0] va[4] = '{8'h00, 8'h05, 8'h42, 8'h01};
    logic [7:0] vb[4] = '{8'h01, 8'h03, 8'h42, 8'hFF};
    logic [7:0] vo[4] = '{8'hFF, 8'h02, 8'h00, 8'h02};
    logic [3:0] vf[4] = '{4'b0001, 4'b0010, 4'b1110, 4'b0011};
    for (int i = 0; i < 4; i++) begin
      drive(va[i], vb[i], 1'b1, 3'b101);
      #1;
      n_total++;
      if ({bus.Out, bus.Zero, bus.Equal, bus.Even, bus.SC_out} !== {vo[i], vf[i]})
        $display("FAIL sub[%0d] got out=%h zeqevc=%b exp out=%h zeqevc=%b", i, bus.Out,
                 {bus.Zero, bus.Equal, bus.Even, bus.SC_out}, vo[i], vf[i]);
      else n_pass++;
    end
  endtask

  task automatic test_logic();
    logic [7:0] va[8] = '{8'hA5, 8'hF0, 8'h04, 8'hFF, 8'h10, 8'h00, 8'h12, 8'hFF};
    logic [7:0] vb[8] = '{8'hA5, 8'h0F, 8'h01, 8'h0F, 8'h01, 8'h00, 8'h34, 8'h00};
    logic [2:0] vp[8] = '{3'b011, 3'b011, 3'b100, 3'b100, 3'b110, 3'b110, 3'b111, 3'b111};
    logic [7:0] vo[8] = '{8'h00, 8'hFF, 8'h00, 8'h0F, 8'h11, 8'h00, 8'h34, 8'h00};
    logic [3:0] vf[8] = '{4'b1110, 4'b0000, 4'b1010, 4'b0000, 4'b0000, 4'b1110, 4'b0010, 4'b1010};
    for (int i = 0; i < 8; i++) begin
      drive(va[i], vb[i], 1'b1, vp[i]);
      #1;
      n_total++;
      if ({bus.Out, bus.Zero, bus.Equal, bus.Even, bus.SC_out} !== {vo[i], vf[i]})
        $display("FAIL logic[%0d] got out=%h zeqevc=%b exp out=%h zeqevc=%b", i, bus.Out,
                 {bus.Zero, bus.Equal, bus.Even, bus.SC_out}, vo[i], vf[i]);
      else n_pass++;
    end
  endtask

  task automatic test_status_reg();
    logic [2:0] q;
    logic [2:0] exp_q;
    // FF+01 wraps to 00 with carry: all three flags set
    @(negedge clk);
    rst = 1'b0;
    drive(8'hFF, 8'h01, 1'b0, 3'b000);
    @(posedge clk); #1;
    q = {bus.Zero_q, bus.SC_q, bus.Even_q};
    exp_q = REG_EN ? 3'b111 : 3'b000;
    n_total++;
    if (q !== exp_q) $display("FAIL status_wrap got=%b exp=%b", q, exp_q);
    else n_pass++;

    @(negedge clk);
    drive(8'h81, 8'h00, 1'b1, 3'b001);
    @(posedge clk); #1;
    q = {bus.Zero_q, bus.SC_q, bus.Even_q};
    exp_q = REG_EN ? 3'b010 : 3'b000;
    n_total++;
    if (q !== exp_q) $display("FAIL status_lsh got=%b exp=%b", q, exp_q);
    else n_pass++;

    @(negedge clk);
    drive(8'h3C, 8'h05, 1'b0, 3'b000);
    @(posedge clk); #1;
    q = {bus.Zero_q, bus.SC_q, bus.Even_q};
    n_total++;
    if (q !== 3'b000) $display("FAIL status_clear got=%b exp=000", q);
    else n_pass++;
  endtask

  task automatic test_reset_midop();
    logic [2:0] q;
    @(negedge clk);
    drive(8'hFF, 8'h01, 1'b0, 3'b000);
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_total++;
    if ({bus.Out, bus.Zero, bus.Equal, bus.Even, bus.SC_out} !== {8'h00, 4'b1011})
      $display("FAIL midop_comb got out=%h zeqevc=%b exp out=00 zeqevc=1011", bus.Out,
               {bus.Zero, bus.Equal, bus.Even, bus.SC_out});
    else n_pass++;
    @(posedge clk); #1;
    q = {bus.Zero_q, bus.SC_q, bus.Even_q};
    n_total++;
    if (q !== 3'b000) $display("FAIL midop_reg got=%b exp=000", q);
    else n_pass++;
    n_total++;
    if (bus.Out !== 8'h00) $display("FAIL midop_out got=%h exp=00", bus.Out);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    drive(8'h00, 8'h00, 1'b0, 3'b000);
    @(negedge clk);
    test_reset();
    test_add();
    test_shift();
    test_sub();
    test_logic();
    test_status_reg();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: ALU

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single system clock; all state updates on rising edge.
REQ-002 SHALL have port Reset, input, 1 bit: synchronous, active-high reset, sampled on rising CLK.
REQ-003 SHALL have port InputA, input, 8 bits: operand A.
REQ-004 SHALL have port InputB, input, 8 bits: operand B.
REQ-005 SHALL have port SC_in, input, 1 bit: shift/carry-in bit.
REQ-006 SHALL have port OP, input, 3 bits: opcode.
REQ-007 SHALL have port Out, output, 8 bits: combinational result.
REQ-008 SHALL have port Zero, output, 1 bit: combinational, 1 when Out == 8'h00.
REQ-009 SHALL have port Equal, output, 1 bit: combinational, 1 when InputA == InputB.
REQ-010 SHALL have port Even, output, 1 bit: combinational, equal to ~Out[0].
REQ-011 SHALL have port SC_out, output, 1 bit: combinational carry/shift-out.
REQ-012 SHALL have ports Zero_q, SC_q, Even_q, output, 1 bit each: registered status flags.

Function
REQ-013 SHALL compute Out combinationally, zero latency, from InputA, InputB, SC_in and OP.
REQ-014 OP 000 ADD SHALL give Out = (InputA + InputB) mod 256 and SC_out = 9th sum bit; SC_in not added.
REQ-015 OP 001 LSH SHALL give Out = {InputA[6:0], SC_in} and SC_out = InputA[7].
REQ-016 OP 010 RSH SHALL give Out = {1'b0, InputA[7:1]} and SC_out = InputA[0]; SC_in ignored.
REQ-017 OP 011 XOR SHALL give Out = InputA ^ InputB and SC_out = 0.
REQ-018 OP 100 AND SHALL give Out = InputA & InputB and SC_out = 0.
REQ-019 OP 101 SUB SHALL give Out = (InputA - InputB) mod 256 and SC_out = 1 when InputA < InputB (unsigned borrow).
REQ-020 OP 110 OR SHALL give Out = InputA | InputB and SC_out = 0.
REQ-021 OP 111 PASS SHALL give Out = InputB and SC_out = 0.
REQ-022 All arithmetic SHALL be unsigned 8-bit with wrap-around; no overflow flag.
REQ-023 Zero, Equal and Even SHALL be valid for every opcode, including wrap-around results.
REQ-024 On each rising CLK with Reset low, Zero_q, SC_q and Even_q SHALL capture Zero, SC_out and Even.
REQ-025 Combinational outputs SHALL NOT depend on Reset or CLK.

Reset
REQ-026 When Reset is high at a rising CLK, Zero_q, SC_q and Even_q SHALL become 0 and override the capture in REQ-024.
REQ-027 Reset asserted mid-operation SHALL NOT affect Out, Zero, Equal, Even or SC_out.

Configuration
REQ-028 Macro ALU_STATUS_REG_EN SHALL control the status register. When the macro is defined, Zero_q, SC_q and Even_q SHALL behave per REQ-024 and REQ-026. When it is undefined, those three outputs SHALL be tied to constant 0, no flops SHALL be inferred, and combinational behaviour SHALL be unchanged.

Verification
REQ-029 InputA=01, InputB=01, OP=000 -> Out=02, Zero=0, Equal=1, Even=1, SC_out=0.
REQ-030 InputA=04, InputB=01, OP=100 -> Out=00, Zero=1, Equal=0, Even=1.
REQ-031 InputA=FF, InputB=01, OP=000 -> Out=00, SC_out=1, Zero=1; then InputA=00, InputB=01, OP=101 -> Out=FF, SC_out=1.
REQ-032 InputA=81, SC_in=1, OP=001 -> Out=03, SC_out=1; then OP=010 -> Out=40, SC_out=1.
REQ-033 With ALU_STATUS_REG_EN defined: InputA=FF, InputB=01, OP=000 with Reset=0, then one CLK edge -> Zero_q=1, SC_q=1, Even_q=1; then Reset=1 and one CLK edge -> all three =0 while Out stays 00.
